// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and drives the
// IF/ID enable/flush controls. Buffers an instruction that returns during a stall.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instruction,
  output logic [31:0] next_imemaddr,
  output logic        enable_IF_ID,
  output logic        flush_IF_ID,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic              halted_q, halted_d;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   redirect_aligned;

  assign pc_plus4         = pc_q + XLEN'(4);
  assign redirect_aligned = redirect_addr & ~XLEN'(3);

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      buf_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and IF/ID control; priority is halt > redirect > stall > ihit
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    halted_d     = halted_q;
    enable_IF_ID = 1'b0;
    flush_IF_ID  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (halt) begin
          flush_IF_ID = 1'b1;
          state_d     = HALTED;
          halted_d    = 1'b1;
        end else if (redirect) begin
          flush_IF_ID = 1'b1;
          pc_d        = redirect_aligned;
        end else if (stall) begin
          if (ihit) begin
            buf_d   = iload;
            state_d = HOLD;
          end
        end else if (ihit) begin
          enable_IF_ID = 1'b1;
          pc_d         = pc_plus4;
        end else begin
          flush_IF_ID = 1'b1;
        end
      end
      HOLD: begin
        if (halt) begin
          flush_IF_ID = 1'b1;
          buf_d       = '0;
          state_d     = HALTED;
          halted_d    = 1'b1;
        end else if (redirect) begin
          flush_IF_ID = 1'b1;
          buf_d       = '0;
          pc_d        = redirect_aligned;
          state_d     = FETCH;
        end else if (!stall) begin
          enable_IF_ID = 1'b1;
          pc_d         = pc_plus4;
          state_d      = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset holds IF/ID quiet regardless of the current state
    if (RST) begin
      enable_IF_ID = 1'b0;
      flush_IF_ID  = 1'b0;
    end
  end

  assign iREN          = (state_q == FETCH);
  assign imemaddr      = pc_q;
  assign next_imemaddr = pc_plus4;
  assign instruction   = (state_q == HOLD) ? buf_q : iload;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks plus a scoreboard of
// instructions expected to be latched into IF/ID.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] instruction;
  logic [31:0] next_imemaddr;
  logic        enable_IF_ID;
  logic        flush_IF_ID;
  logic        halted;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .iREN(iREN), .imemaddr(imemaddr), .instruction(instruction),
    .next_imemaddr(next_imemaddr), .enable_IF_ID(enable_IF_ID),
    .flush_IF_ID(flush_IF_ID), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every IF/ID enable must match the oldest expected fetch
  always begin
    @(negedge CLK);
    #2;
    if (!RST) begin
      checks++;
      if (enable_IF_ID === 1'b1 && flush_IF_ID === 1'b1) begin
        errors++;
        $display("FAIL en_flush_excl: both enable and flush asserted at %0t", $time);
      end
      if (enable_IF_ID === 1'b1) begin
        logic [63:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: enable with instr=%h npc=%h, nothing expected", instruction, next_imemaddr);
        end else begin
          exp = sb_q.pop_front();
          if ({instruction, next_imemaddr} !== exp) begin
            errors++;
            $display("FAIL sb_latch: got instr=%h npc=%h, want instr=%h npc=%h",
                     instruction, next_imemaddr, exp[63:32], exp[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; iload = '0; stall = 0; redirect = 0; redirect_addr = '0; halt = 0;
  endtask

  task automatic drive_redirect(input logic [31:0] addr);
    idle_inputs();
    redirect = 1; redirect_addr = addr;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    RST = 1;
    idle_inputs();
    tick();
    tick();
    @(negedge CLK);
    checks++;
    if ({imemaddr, next_imemaddr} !== {32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reset_pc: pc=%h npc=%h, want 0/4", imemaddr, next_imemaddr);
    end
    checks++;
    if ({iREN, enable_IF_ID, flush_IF_ID, halted} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl: iREN/en/flush/halted=%b, want 1000",
               {iREN, enable_IF_ID, flush_IF_ID, halted});
    end
    tick();
    RST = 0;
  endtask

  task automatic test_stream();
    logic [31:0] vals[3];
    vals[0] = 32'h2001_0001; vals[1] = 32'h2002_0002; vals[2] = 32'h2003_0003;
    for (int i = 0; i < 3; i++) begin
      ihit = 1; iload = vals[i];
      sb_q.push_back({vals[i], 32'(4 * (i + 1))});
      @(negedge CLK);
      checks++;
      if (imemaddr !== 32'(4 * i) || enable_IF_ID !== 1'b1 || instruction !== vals[i]) begin
        errors++;
        $display("FAIL stream[%0d]: pc=%h en=%b instr=%h, want pc=%h en=1 instr=%h",
                 i, imemaddr, enable_IF_ID, instruction, 32'(4 * i), vals[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    drive_redirect(32'h8);
    ihit = 1; iload = 32'hDEAD_BEEF; stall = 1;
    @(negedge CLK);
    checks++;
    if ({iREN, enable_IF_ID, flush_IF_ID} !== 3'b100 || imemaddr !== 32'h8) begin
      errors++;
      $display("FAIL stall_capture: iREN/en/flush=%b pc=%h, want 100 pc=8",
               {iREN, enable_IF_ID, flush_IF_ID}, imemaddr);
    end
    tick();
    ihit = 0; iload = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({iREN, enable_IF_ID, flush_IF_ID} !== 3'b000 || imemaddr !== 32'h8 ||
          instruction !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: iREN/en/flush=%b pc=%h instr=%h, want 000 pc=8 instr=deadbeef",
                 i, {iREN, enable_IF_ID, flush_IF_ID}, imemaddr, instruction);
      end
      tick();
    end
    stall = 0;
    sb_q.push_back({32'hDEAD_BEEF, 32'hC});
    @(negedge CLK);
    checks++;
    if (enable_IF_ID !== 1'b1 || instruction !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stall_release: en=%b instr=%h, want en=1 instr=deadbeef", enable_IF_ID, instruction);
    end
    tick();
    idle_inputs();
    stall = 1;
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'hC || iREN !== 1'b1) begin
      errors++;
      $display("FAIL stall_after: pc=%h iREN=%b, want pc=c iREN=1", imemaddr, iREN);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_hold_redirect();
    ihit = 1; iload = 32'h1111_1111; stall = 1;
    tick();
    ihit = 0; redirect = 1; redirect_addr = 32'h0000_0103;
    @(negedge CLK);
    checks++;
    if ({enable_IF_ID, flush_IF_ID} !== 2'b01) begin
      errors++;
      $display("FAIL hold_redirect: en/flush=%b, want 01", {enable_IF_ID, flush_IF_ID});
    end
    tick();
    redirect = 0; iload = 32'h5555_5555;
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'h100 || iREN !== 1'b1 || instruction !== 32'h5555_5555) begin
      errors++;
      $display("FAIL hold_redirect_after: pc=%h iREN=%b instr=%h, want pc=100 iREN=1 instr=55555555",
               imemaddr, iREN, instruction);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_bubble();
    drive_redirect(32'h10);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if ({enable_IF_ID, flush_IF_ID} !== 2'b01 || imemaddr !== 32'h10) begin
        errors++;
        $display("FAIL bubble[%0d]: en/flush=%b pc=%h, want 01 pc=10", i, {enable_IF_ID, flush_IF_ID}, imemaddr);
      end
      tick();
    end
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'h10) begin
      errors++;
      $display("FAIL bubble_pc: pc=%h, want 10", imemaddr);
    end
    tick();
  endtask

  task automatic test_halt();
    drive_redirect(32'h20);
    halt = 1; redirect = 1; redirect_addr = 32'h40; ihit = 1; iload = 32'h7777_7777;
    @(negedge CLK);
    checks++;
    if ({enable_IF_ID, flush_IF_ID} !== 2'b01) begin
      errors++;
      $display("FAIL halt_flush: en/flush=%b, want 01", {enable_IF_ID, flush_IF_ID});
    end
    tick();
    halt = 0;
    for (int i = 0; i < 5; i++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge CLK);
      checks++;
      if ({halted, iREN, enable_IF_ID, flush_IF_ID} !== 4'b1000 || imemaddr !== 32'h20) begin
        errors++;
        $display("FAIL halted[%0d]: halted/iREN/en/flush=%b pc=%h, want 1000 pc=20",
                 i, {halted, iREN, enable_IF_ID, flush_IF_ID}, imemaddr);
      end
      tick();
    end
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'h0 || halted !== 1'b0 || iREN !== 1'b1) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b iREN=%b, want pc=0 halted=0 iREN=1", imemaddr, halted, iREN);
    end
    tick();
  endtask

  task automatic test_wrap();
    drive_redirect(32'hFFFF_FFFC);
    ihit = 1; iload = 32'hCAFE_F00D;
    sb_q.push_back({32'hCAFE_F00D, 32'h0});
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'hFFFF_FFFC || next_imemaddr !== 32'h0 || enable_IF_ID !== 1'b1) begin
      errors++;
      $display("FAIL wrap: pc=%h npc=%h en=%b, want fffffffc/0/1", imemaddr, next_imemaddr, enable_IF_ID);
    end
    tick();
    idle_inputs();
    @(negedge CLK);
    checks++;
    if (imemaddr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h, want 0", imemaddr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc_m;
    logic        h;
    pc_m = 32'h0;
    for (int i = 0; i < 10; i++) begin
      h = 1'($urandom_range(0, 1));
      ihit = h; iload = $urandom;
      if (h) sb_q.push_back({iload, pc_m + 32'h4});
      @(negedge CLK);
      checks++;
      if (imemaddr !== pc_m || enable_IF_ID !== h || flush_IF_ID !== !h) begin
        errors++;
        $display("FAIL b2b[%0d]: pc=%h en=%b flush=%b, want pc=%h en=%b flush=%b",
                 i, imemaddr, enable_IF_ID, flush_IF_ID, pc_m, h, !h);
      end
      tick();
      if (h) pc_m = pc_m + 32'h4;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_hold_redirect();
    test_bubble();
    test_halt();
    test_wrap();
    test_back_to_back();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected fetches never latched, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues instruction-memory reads, and supplies the instruction, fetch address and PC+4 to IF/ID.
- Generates the IF/ID enable/flush controls from hazard stalls, branch/jump redirects and halt.
- Buffers an instruction that returns during a stall so it is not re-fetched.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
ihit  input  1  instruction memory returns valid data this cycle.
iload  input  32  instruction data from memory, valid when ihit=1.
stall  input  1  hazard unit request to freeze IF and IF/ID.
redirect  input  1  branch taken / jump resolved downstream; refetch from redirect_addr.
redirect_addr  input  32  redirect target.
halt  input  1  halt instruction detected downstream.
iREN  output  1  instruction memory read enable.
imemaddr  output  32  current PC / fetch address.
instruction  output  32  instruction presented to IF/ID.
next_imemaddr  output  32  PC+4 of the presented instruction.
enable_IF_ID  output  1  IF/ID latches the presented fields this cycle.
flush_IF_ID  output  1  IF/ID loads a bubble (all zero) this cycle; dominates enable.
halted  output  1  fetch permanently stopped.

Behaviour:
- Registers:
  - PC, reset PC_INIT.
  - buf, 32 bits, reset 0.
  - state ∈ {FETCH, HOLD, HALTED}, reset FETCH.
  - halted, reset 0.
- Combinational outputs:
  - imemaddr = PC.
  - next_imemaddr = PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - instruction = buf in HOLD, else iload.
  - iREN = 1 only in FETCH.
- Reset outputs: imemaddr=PC_INIT, iREN=1, enable=0, flush=0, halted=0.
- Event priority each cycle: RST > halt > redirect > stall > ihit.
- FETCH:
  - halt: flush=1, enable=0; next state HALTED, halted<=1; PC unchanged.
  - redirect: flush=1, enable=0; PC<=redirect_addr with bits[1:0] forced 00; any ihit this cycle discarded; stay FETCH.
  - stall & ihit: buf<=iload; enable=0, flush=0; PC unchanged; go HOLD.
  - stall & !ihit: enable=0, flush=0; hold.
  - !stall & ihit: enable=1, flush=0; PC<=PC+4.
  - !stall & !ihit: enable=0, flush=1 (bubble); PC unchanged.
- HOLD (memory idle, buf valid):
  - halt: as in FETCH; buf discarded.
  - redirect: flush=1; PC<=redirect_addr aligned; buf discarded; go FETCH.
  - stall: enable=0, flush=0; hold.
  - else: enable=1, instruction=buf; PC<=PC+4; go FETCH.
- HALTED:
  - iREN=0, enable=0, flush=0, halted=1.
  - PC frozen; ihit, stall and redirect ignored.
  - Exit only via RST.
- Latency: instruction reaches IF/ID in the same cycle as ihit when not stalled; PC advances the cycle after.
- RST mid-operation (any state): next cycle is the reset state; buf contents discarded.
- enable and flush are never both 1.

Test Plan:
- RST=1 for 2 cycles, PC_INIT=0 → imemaddr=0, next_imemaddr=4, iREN=1, enable=0, flush=0, halted=0.
- ihit=1 every cycle, iload=0x2001_0001, 0x2002_0002, 0x2003_0003 → imemaddr 0,4,8; enable=1 each cycle; next_imemaddr 4,8,0xC; instruction follows iload.
- At PC=8: ihit=1, iload=0xDEAD_BEEF, stall=1 for 3 cycles → state HOLD, iREN=0, imemaddr=8, enable=0 throughout. On stall release: instruction=0xDEAD_BEEF, enable=1; next cycle PC=0xC, iREN=1.
- In HOLD, redirect=1 with redirect_addr=0x0000_0103 → flush=1, enable=0; next PC=0x100, state FETCH, buf discarded. Same-cycle stall=1 does not block the redirect.
- ihit=0 for 2 cycles, stall=0, PC=0x10 → flush=1, enable=0 both cycles; PC stays 0x10.
- At PC=0x20: halt=1 with redirect=1 and ihit=1 → flush=1 that cycle; then halted=1, iREN=0, PC=0x20 held for 5 cycles despite ihit/redirect; RST → PC=PC_INIT, halted=0.
- Wrap: PC forced to 0xFFFF_FFFC, ihit=1 → next PC=0, next_imemaddr=0 during that cycle.
